// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, keeps one imem request in flight and buffers one word for decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a registered pulse on misaligned redirect targets.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misaligned_err
);

    typedef enum logic [1:0] {REQUEST, WAIT_RSP, HOLD, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] inst_data_reg, inst_data_next;
    logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
    logic            inst_valid_reg;
    logic [XLEN-1:0] target;

    assign target = redirect_pc & ~XLEN'(3);

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        inst_data_next = inst_data_reg;
        inst_pc_next   = inst_pc_reg;
        case (state_reg)
            REQUEST: begin
                if (redirect_en) begin
                    pc_next = target;
                    if (imem_req_ready) state_next = DRAIN;
                end else if (imem_req_ready) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (redirect_en) begin
                    pc_next    = target;
                    state_next = imem_rsp_valid ? REQUEST : DRAIN;
                end else if (imem_rsp_valid) begin
                    inst_data_next = imem_rsp_data;
                    inst_pc_next   = pc_reg;
                    pc_next        = pc_reg + XLEN'(4);
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    pc_next    = target;
                    state_next = REQUEST;
                end else if (inst_ready) begin
                    state_next = REQUEST;
                end
            end
            DRAIN: begin
                // A redirect only retargets pc; the stale response still ends the drain.
                if (redirect_en) pc_next = target;
                if (imem_rsp_valid) state_next = REQUEST;
            end
            default: state_next = REQUEST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= REQUEST;
            pc_reg         <= RESET_VECTOR;
            inst_data_reg  <= '0;
            inst_pc_reg    <= '0;
            inst_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_data_reg  <= inst_data_next;
            inst_pc_reg    <= inst_pc_next;
            inst_valid_reg <= (state_next == HOLD);
        end
    end

    assign imem_req_valid = rst_n && (state_reg == REQUEST);
    assign imem_req_addr  = pc_reg;
    assign inst_valid     = inst_valid_reg;
    assign inst_data      = inst_data_reg;
    assign inst_pc        = inst_pc_reg;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misaligned_reg <= 1'b0;
        else        misaligned_reg <= redirect_en && (redirect_pc[1:0] != 2'b00);
    end

    assign misaligned_err = misaligned_reg;
`else
    assign misaligned_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency, scoreboard queues
// for expected request addresses and expected decode-side instructions.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misaligned_err;

    int checks = 0;
    int errors = 0;
    int n_inst = 0;
    int expect_n = 0;
    int lat = 1;
    int cnt = 0;
    logic [31:0] pend_addr;
    logic [31:0] req_q[$];
    exp_t        inst_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .misaligned_err(misaligned_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_inst(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = mem_word(a);
        inst_q.push_back(e);
        expect_n++;
    endtask

    // Waits for decode to take expect_n instructions, then stops fetching and moves past the handshake.
    task automatic wait_insts();
        for (int i = 0; i < 100 && n_inst < expect_n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("inst_count", n_inst, expect_n);
        imem_req_ready = 1'b0;
        step(1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) step(1);
        chk("wait_valid", inst_valid, 1);
    endtask

    // Instruction memory: response fires k negedges after the accept was seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt            = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr = imem_req_addr;
                cnt       = lat;
            end
        end
    end

    // Scoreboard: compare accepted requests and decode handshakes against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                $display("%0t req  addr=%h", $time, imem_req_addr);
                checks++;
                assert (req_q.size() != 0) else begin
                    errors++;
                    $error("FAIL req_unexpected observed=%h expected=none", imem_req_addr);
                end
                if (req_q.size() != 0) chk("req_addr", imem_req_addr, req_q.pop_front());
            end
            if (inst_valid && inst_ready) begin
                $display("%0t inst pc=%h data=%h", $time, inst_pc, inst_data);
                n_inst++;
                checks++;
                assert (inst_q.size() != 0) else begin
                    errors++;
                    $error("FAIL inst_unexpected observed=%h expected=none", inst_pc);
                end
                if (inst_q.size() != 0) begin
                    exp_t e;
                    e = inst_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_data", inst_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        step(2);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misaligned", misaligned_err, 0);
        rst_n = 1'b1;

        // Sequential fetch, latency 1
        lat = 1;
        req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
        push_inst(32'h0); push_inst(32'h4); push_inst(32'h8);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step(1);
        chk("t1_valid_after_accept", inst_valid, 0);
        step(1);
        chk("t1_valid_two_after", inst_valid, 1);
        chk("t1_first_pc", inst_pc, 32'h0);
        wait_insts();

        // Async reset mid-operation, then decode stall in HOLD
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_inst_pc", inst_pc, 32'h0);
        chk("mid_rst_req_addr", imem_req_addr, 32'h0);
        step(1);
        rst_n = 1'b1;
        req_q.push_back(32'h0);
        push_inst(32'h0);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", inst_valid, 1);
            chk("t2_data", inst_data, 32'h0050_0093);
            chk("t2_pc", inst_pc, 32'h0);
            chk("t2_no_req", imem_req_valid, 0);
            step(1);
        end
        inst_ready     = 1'b1;
        imem_req_ready = 1'b0;
        step(1);
        chk("t2_next_req_valid", imem_req_valid, 1);
        chk("t2_next_req_addr", imem_req_addr, 32'h4);

        // Redirect during WAIT_RSP, latency 3
        lat = 3;
        req_q.push_back(32'h4);
        imem_req_ready = 1'b1;
        step(1);
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        req_q.push_back(32'h100);
        push_inst(32'h100);
        step(1);
        redirect_en = 1'b0;
        chk("t3_drain_req", imem_req_valid, 0);
        chk("t3_drain_valid", inst_valid, 0);
        step(1);
        chk("t3_drain_req2", imem_req_valid, 0);
        step(1);
        chk("t3_req_valid", imem_req_valid, 1);
        chk("t3_req_addr", imem_req_addr, 32'h100);
        chk("t3_no_stale", inst_valid, 0);
        wait_insts();

        // Redirect in HOLD with decode stalled
        lat = 1;
        req_q.push_back(32'h104);
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        wait_valid();
        chk("t4_hold_pc", inst_pc, 32'h104);
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        req_q.push_back(32'h200);
        push_inst(32'h200);
        step(1);
        redirect_en = 1'b0;
        chk("t4_valid_cleared", inst_valid, 0);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        inst_ready = 1'b1;
        wait_insts();

        // PC wrap at the top of the address space
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_en = 1'b0;
        chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        req_q.push_back(32'hFFFF_FFFC);
        push_inst(32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        wait_insts();
        chk("t5_wrap_valid", imem_req_valid, 1);
        chk("t5_wrap_addr", imem_req_addr, 32'h0);

        // Misaligned redirect target
        redirect_en = 1'b1;
        redirect_pc = 32'h102;
        step(1);
        redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t6_misaligned", misaligned_err, 1);
`else
        chk("t6_misaligned", misaligned_err, 0);
`endif
        chk("t6_req_addr", imem_req_addr, 32'h100);
        step(1);
        chk("t6_misaligned_pulse", misaligned_err, 0);
        req_q.push_back(32'h100);
        push_inst(32'h100);
        imem_req_ready = 1'b1;
        wait_insts();

        // Redirect on accept, then back-to-back redirects in DRAIN
        lat = 2;
        req_q.push_back(32'h104);
        imem_req_ready = 1'b1;
        redirect_en    = 1'b1;
        redirect_pc    = 32'h300;
        step(1);
        chk("t7_drain", imem_req_valid, 0);
        redirect_pc = 32'h400;
        step(1);
        redirect_en = 1'b0;
        chk("t7_drain2", imem_req_valid, 0);
        req_q.push_back(32'h400);
        push_inst(32'h400);
        wait_insts();

        step(3);
        chk("req_q_empty", req_q.size(), 0);
        chk("inst_q_empty", inst_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
